// File: rtl/inst_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_encoder_if
// Brief    : Field-in / word-out stream bundle for inst_encoder.
// Revision : 1.0  initial release
// ============================================================================
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  opcode;
    logic [2:0]  func;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [7:0]  imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic        out_err;
    logic [7:0]  out_addr;

    modport slave (
        input  in_valid, opcode, func, rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, out_word, out_err, out_addr
    );

    modport master (
        output in_valid, opcode, func, rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, out_word, out_err, out_addr
    );
endinterface
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : inst_encoder
// Brief    : Packs instruction fields into 16-bit words behind a 2-entry FIFO
//            with word address and error counters. ENC_RANGE_CHECK_EN enables
//            immediate range errors.
// Revision : 1.0  initial release
// ============================================================================
module inst_encoder (
    input  wire logic        clk,
    input  wire logic        rst_n,
    inst_encoder_if.slave    bus,
    input  wire logic        addr_load,
    input  wire logic [7:0]  addr_base,
    output logic [3:0]       err_count
);
`ifdef ENC_RANGE_CHECK_EN
    localparam bit c_RANGE_CHECK = 1'b1;
`else
    localparam bit c_RANGE_CHECK = 1'b0;
`endif

    logic [15:0] w_enc_word;
    logic        w_range_bad;
    logic        w_rsvd;
    logic        w_enc_err;

    always_comb begin
        w_enc_word      = '0;
        w_enc_word[2:0] = bus.opcode;
        w_range_bad     = 1'b0;
        w_rsvd          = 1'b0;
        case (bus.opcode)
            3'b000: begin
                w_enc_word[5:3]   = bus.func;
                w_enc_word[8:6]   = bus.rd;
                w_enc_word[11:9]  = bus.rs1;
                w_enc_word[14:12] = bus.rs2;
            end
            3'b001: begin
                w_enc_word[5:3]   = bus.func;
                w_enc_word[8:6]   = bus.rd;
                w_enc_word[11:9]  = bus.rs1;
                w_enc_word[14:12] = bus.imm[2:0];
                w_enc_word[15]    = bus.imm[7];
                w_range_bad       = (bus.imm[7:3] != 5'h00) && (bus.imm[7:3] != 5'h1F);
            end
            3'b010, 3'b011: begin
                w_enc_word[5:3]   = bus.imm[2:0];
                w_enc_word[8:6]   = bus.rd;
                w_enc_word[11:9]  = bus.rs1;
                w_enc_word[14:12] = bus.imm[5:3];
                w_enc_word[15]    = bus.imm[7];
                w_range_bad       = bus.imm[7] != bus.imm[6];
            end
            3'b100: begin
                w_enc_word[5:3]   = bus.func;
                w_enc_word[8:6]   = bus.imm[2:0];
                w_enc_word[11:9]  = bus.rs1;
                w_enc_word[14:12] = bus.rs2;
                w_enc_word[15]    = bus.imm[7];
                w_range_bad       = (bus.imm[7:3] != 5'h00) && (bus.imm[7:3] != 5'h1F);
            end
            3'b101: begin
                w_enc_word[5:3] = bus.func;
                w_enc_word[8:6] = bus.rd;
                if (bus.func == 3'b000) begin
                    w_enc_word[15:9] = bus.imm[6:0];
                    w_range_bad      = bus.imm[7];
                end else if (bus.func == 3'b100) begin
                    w_enc_word[15:12] = bus.imm[7:4];
                    w_enc_word[11:9]  = bus.rs1;
                    w_range_bad       = bus.imm[3:0] != 4'h0;
                end
            end
            3'b110: begin
                w_enc_word[5:3] = bus.func;
                w_enc_word[8:6] = bus.rd;
                if (bus.func == 3'b001) begin
                    w_enc_word[14:9] = bus.imm[5:0];
                    w_enc_word[15]   = bus.imm[7];
                    w_range_bad      = bus.imm[7] != bus.imm[6];
                end else if (bus.func == 3'b000) begin
                    w_enc_word[15:12] = bus.imm[7:4];
                    w_enc_word[11:9]  = bus.rs1;
                    w_range_bad       = bus.imm[3:0] != 4'h0;
                end
            end
            default: begin
                w_rsvd = 1'b1;
            end
        endcase
    end

    assign w_enc_err = w_rsvd | (c_RANGE_CHECK & w_range_bad);

    // Each entry holds {err, word}
    logic [16:0] mem_q [2];
    logic        rd_ptr_q, wr_ptr_q;
    logic [1:0]  count_q, count_d;
    logic [7:0]  addr_q, addr_d;
    logic [3:0]  errcnt_q, errcnt_d;
    logic [16:0] w_head;
    logic        w_push, w_pop;

    assign w_head        = mem_q[rd_ptr_q];
    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_word  = bus.out_valid ? w_head[15:0] : 16'h0000;
    assign bus.out_err   = bus.out_valid & w_head[16];
    assign bus.out_addr  = addr_q;
    assign err_count     = errcnt_q;

    assign w_push = bus.in_valid & bus.in_ready;
    assign w_pop  = bus.out_valid & bus.out_ready;

    always_comb begin
        count_d  = count_q;
        addr_d   = addr_q;
        errcnt_d = errcnt_q;
        if (w_push && !w_pop)
            count_d = count_q + 2'd1;
        else if (!w_push && w_pop)
            count_d = count_q - 2'd1;
        // A load wins over the pop increment; the pop itself still happens.
        if (addr_load)
            addr_d = addr_base;
        else if (w_pop)
            addr_d = addr_q + 8'd1;
        if (w_pop && bus.out_err && (errcnt_q != 4'hF))
            errcnt_d = errcnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            addr_q   <= 8'd0;
            errcnt_q <= 4'd0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= {w_enc_err, w_enc_word};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop)
                rd_ptr_q <= ~rd_ptr_q;
            count_q  <= count_d;
            addr_q   <= addr_d;
            errcnt_q <= errcnt_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_encoder
// Brief    : Directed vector table plus handshake, address and error sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_inst_encoder;
`ifdef ENC_RANGE_CHECK_EN
    localparam logic c_RC = 1'b1;
`else
    localparam logic c_RC = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [2:0]  op, fn, rd, rs1, rs2;
        logic [7:0]  imm;
        logic [15:0] word;
        logic        err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       addr_load;
    logic [7:0] addr_base;
    logic [3:0] err_count;
    int         n_checks = 0;
    int         n_errors = 0;
    vec_t       vt [20];

    inst_encoder_if bus ();

    inst_encoder u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .addr_load (addr_load),
        .addr_base (addr_base),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input logic [2:0] op, fn, rd, rs1, rs2,
                                input logic [7:0] imm, input logic [15:0] w, input logic e);
        vec_t v;
        v.name = n; v.op = op; v.fn = fn; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.word = w; v.err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_fields(input logic [2:0] op, fn, rd, rs1, rs2, input logic [7:0] imm);
        bus.opcode = op; bus.func = fn; bus.rd = rd;
        bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
    endtask

    task automatic push_pop(input vec_t v);
        set_fields(v.op, v.fn, v.rd, v.rs1, v.rs2, v.imm);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({v.name, " valid"}, {15'd0, bus.out_valid}, 16'd1);
        chk({v.name, " word"}, bus.out_word, v.word);
        chk({v.name, " err"}, {15'd0, bus.out_err}, {15'd0, v.err});
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({v.name, " popped"}, {15'd0, bus.out_valid}, 16'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vt[0]  = mk("R",        3'd0, 3'd2, 3'd3, 3'd5, 3'd6, 8'h00, 16'h6AD0, 1'b0);
        vt[1]  = mk("I-8",      3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 8'hF8, 16'h8001, 1'b0);
        vt[2]  = mk("I+8",      3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 8'h08, 16'h0001, c_RC);
        vt[3]  = mk("I+7",      3'd1, 3'd7, 3'd1, 3'd2, 3'd0, 8'h07, 16'h7479, 1'b0);
        vt[4]  = mk("L+63",     3'd2, 3'd0, 3'd2, 3'd3, 3'd0, 8'h3F, 16'h76BA, 1'b0);
        vt[5]  = mk("S+64",     3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 8'h40, 16'h0003, c_RC);
        vt[6]  = mk("S-64",     3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 8'hC0, 16'h8003, 1'b0);
        vt[7]  = mk("B-3",      3'd4, 3'd1, 3'd7, 3'd4, 3'd5, 8'hFD, 16'hD94C, 1'b0);
        vt[8]  = mk("B-16",     3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 8'hF0, 16'h8004, c_RC);
        vt[9]  = mk("JAL127",   3'd5, 3'd0, 3'd1, 3'd0, 3'd0, 8'h7F, 16'hFE45, 1'b0);
        vt[10] = mk("JAL128",   3'd5, 3'd0, 3'd1, 3'd0, 3'd0, 8'h80, 16'h0045, c_RC);
        vt[11] = mk("JALR",     3'd5, 3'd4, 3'd2, 3'd3, 3'd0, 8'hA0, 16'hA6A5, 1'b0);
        vt[12] = mk("JALRbad",  3'd5, 3'd4, 3'd2, 3'd3, 3'd0, 8'hA4, 16'hA6A5, c_RC);
        vt[13] = mk("J-other",  3'd5, 3'd3, 3'd7, 3'd7, 3'd7, 8'hFF, 16'h01DD, 1'b0);
        vt[14] = mk("ADDPC63",  3'd6, 3'd1, 3'd4, 3'd0, 3'd0, 8'h3F, 16'h7F0E, 1'b0);
        vt[15] = mk("ADDPCbad", 3'd6, 3'd1, 3'd4, 3'd0, 3'd0, 8'h80, 16'h810E, c_RC);
        vt[16] = mk("AUIR",     3'd6, 3'd0, 3'd5, 3'd6, 3'd0, 8'h50, 16'h5D46, 1'b0);
        vt[17] = mk("AUIRbad",  3'd6, 3'd0, 3'd5, 3'd6, 3'd0, 8'h51, 16'h5D46, c_RC);
        vt[18] = mk("U-other",  3'd6, 3'd2, 3'd0, 3'd0, 3'd0, 8'hFF, 16'h0016, 1'b0);
        vt[19] = mk("RSVD",     3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 8'hFF, 16'h0007, 1'b1);

        rst_n = 1'b0; addr_load = 1'b0; addr_base = 8'h00;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        set_fields(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        repeat (2) @(negedge clk);
        chk("rst out_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("rst in_ready",  {15'd0, bus.in_ready}, 16'd1);
        chk("rst out_word",  bus.out_word, 16'h0000);
        chk("rst out_err",   {15'd0, bus.out_err}, 16'd0);
        chk("rst out_addr",  {8'd0, bus.out_addr}, 16'd0);
        chk("rst err_count", {12'd0, err_count}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 20; i++) push_pop(vt[i]);
        chk("table addr", {8'd0, bus.out_addr}, 16'd20);
        chk("table err_count", {12'd0, err_count}, c_RC ? 16'd8 : 16'd1);

        // Backpressure: three offered, two accepted, drained in order
        pulse_reset();
        set_fields(3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 8'h00);
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("bp ready@1", {15'd0, bus.in_ready}, 16'd1);
        bus.rd = 3'd2;
        @(negedge clk);
        chk("bp ready@2", {15'd0, bus.in_ready}, 16'd0);
        bus.rd = 3'd3;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp stall ready", {15'd0, bus.in_ready}, 16'd0);
            chk("bp stall word", bus.out_word, 16'h0040);
            chk("bp stall addr", {8'd0, bus.out_addr}, 16'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp word1", bus.out_word, 16'h0080);
        chk("bp addr1", {8'd0, bus.out_addr}, 16'd1);
        chk("bp ready free", {15'd0, bus.in_ready}, 16'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp word2", bus.out_word, 16'h00C0);
        chk("bp addr2", {8'd0, bus.out_addr}, 16'd2);
        chk("bp valid2", {15'd0, bus.out_valid}, 16'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp drained", {15'd0, bus.out_valid}, 16'd0);
        chk("bp addr3", {8'd0, bus.out_addr}, 16'd3);

        // Address load and wrap
        addr_load = 1'b1; addr_base = 8'hFF;
        @(negedge clk);
        addr_load = 1'b0;
        chk("load FF", {8'd0, bus.out_addr}, 16'h00FF);
        set_fields(3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 8'h00);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.rd = 3'd5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("wrap word FF", bus.out_word, 16'h0100);
        chk("wrap addr FF", {8'd0, bus.out_addr}, 16'h00FF);
        @(negedge clk);
        chk("wrap word 00", bus.out_word, 16'h0140);
        chk("wrap addr 00", {8'd0, bus.out_addr}, 16'h0000);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("wrap addr 01", {8'd0, bus.out_addr}, 16'h0001);
        set_fields(3'd0, 3'd0, 3'd6, 3'd0, 3'd0, 8'h00);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        addr_load = 1'b1; addr_base = 8'h40;
        @(negedge clk);
        bus.out_ready = 1'b0; addr_load = 1'b0;
        chk("load vs pop addr", {8'd0, bus.out_addr}, 16'h0040);
        chk("load vs pop popped", {15'd0, bus.out_valid}, 16'd0);

        // Error counter saturation
        pulse_reset();
        set_fields(3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        for (int k = 0; k < 16; k++) begin
            bus.in_valid = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            if (k == 14) chk("errcnt at 15", {12'd0, err_count}, 16'd15);
        end
        chk("errcnt saturated", {12'd0, err_count}, 16'd15);

        // Reset with two buffered words
        bus.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("pre-rst valid", {15'd0, bus.out_valid}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst valid",  {15'd0, bus.out_valid}, 16'd0);
        chk("async rst errcnt", {12'd0, err_count}, 16'd0);
        chk("async rst ready",  {15'd0, bus.in_ready}, 16'd1);
        chk("async rst word",   bus.out_word, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        set_fields(3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 8'h00);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("post-rst word", bus.out_word, 16'h01C0);
        chk("post-rst addr", {8'd0, bus.out_addr}, 16'd0);
        chk("post-rst err",  {15'd0, bus.out_err}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
